vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 75 +++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/counter generator advancing one pixel per clk_en
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   clk_en     pixel tick
//   hsync      horizontal sync (level SYNC_POL while in the pulse), registered
//   vsync      vertical sync (level SYNC_POL while in the pulse), registered
//   video_on   active-region flag, registered
//   x, y       current pixel / line counters
//   line_end   clk_en on the last pixel of a line
//   frame_end  line_end on the last line of a frame
//   frame_count  8-bit frame counter, present only with VGA_FRAME_COUNT_EN
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_end,
`ifdef VGA_FRAME_COUNT_EN
  output logic [7:0] frame_count,
`endif
  output logic       frame_end
);
  localparam logic [9:0] HT_M1 = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VT_M1 = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_B  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_E  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_B  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_E  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] HA    = 10'(H_ACTIVE);
  localparam logic [9:0] VA    = 10'(V_ACTIVE);
  logic       x_last, y_last;
  logic [9:0] x_n, y_n;
  assign x_last    = x == HT_M1;
  assign y_last    = y == VT_M1;
  assign x_n       = x_last ? '0 : x + 10'd1;
  assign y_n       = x_last ? (y_last ? '0 : y + 10'd1) : y;
  assign line_end  = clk_en && x_last;
  assign frame_end = line_end && y_last;
  // Sync/video decoded from the next count so they land on the same edge as x/y.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x        <= '0;
      y        <= '0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
      video_on <= 1'b1;
    end else if (clk_en) begin
      x        <= x_n;
      y        <= y_n;
      hsync    <= (x_n >= HS_B && x_n <= HS_E) ? SYNC_POL : ~SYNC_POL;
      vsync    <= (y_n >= VS_B && y_n <= VS_E) ? SYNC_POL : ~SYNC_POL;
      video_on <= x_n < HA && y_n < VA;
    end
  end
`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_count <= '0;
    else if (frame_end) frame_count <= frame_count + 8'd1;
  end
`endif
endmodule
